// File: rtl/ave8_bcd_display_if.sv
// Sample handshake between the moving-average block (master) and the
// BCD display stage (slave). Bit 0 of in_data is the MSB.
interface ave8_bcd_display_if;
    logic [0:7] in_data;
    logic       in_valid;
    logic       in_ready;

    modport master (output in_data, output in_valid, input in_ready);
    modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/ave8_bcd_display.sv
// Display stage: accepts an 8-bit average, converts it to three BCD digits
// by double-dabble over 8 cycles, and drives active-low seven-segment outputs.
module ave8_bcd_display #(
    parameter bit BLANK_LZ = 1'b1
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    ave8_bcd_display_if.slave    in_if,
    output logic [0:3]           bcd_hun,
    output logic [0:3]           bcd_tens,
    output logic [0:3]           bcd_units,
    output logic [0:6]           seg_hun,
    output logic [0:6]           seg_tens,
    output logic [0:6]           seg_units,
    output logic                 disp_valid
);

    typedef enum logic [1:0] {IDLE, CONV, LOAD} state_t;

    localparam logic [0:6] SEG_BLANK = 7'b1111111;

    state_t      state;
    state_t      state_next;
    logic [19:0] shift_reg;   // [19:16] hundreds, [15:12] tens, [11:8] units, [7:0] binary
    logic [2:0]  iter;
    logic        ready;
    logic        accept;
    logic        hun_zero;
    logic        tens_zero;

    function automatic logic [0:6] seg_encode(input logic [3:0] digit);
        case (digit)
            4'd0:    seg_encode = 7'b0000001;
            4'd1:    seg_encode = 7'b1001111;
            4'd2:    seg_encode = 7'b0010010;
            4'd3:    seg_encode = 7'b0000110;
            4'd4:    seg_encode = 7'b1001100;
            4'd5:    seg_encode = 7'b0100100;
            4'd6:    seg_encode = 7'b0100000;
            4'd7:    seg_encode = 7'b0001111;
            4'd8:    seg_encode = 7'b0000000;
            4'd9:    seg_encode = 7'b0000100;
            default: seg_encode = SEG_BLANK;
        endcase
    endfunction

    // One double-dabble iteration: add-3 correction on each nibble, then shift.
    function automatic logic [19:0] dabble_step(input logic [19:0] sr);
        logic [19:0] t;
        t = sr;
        for (int n = 0; n < 3; n++) begin
            if (t[8 + 4*n +: 4] >= 4'd5)
                t[8 + 4*n +: 4] = t[8 + 4*n +: 4] + 4'd3;
        end
        return {t[18:0], 1'b0};
    endfunction

    assign accept       = in_if.in_valid && ready && (state == IDLE);
    assign in_if.in_ready = ready;
    assign hun_zero     = (shift_reg[19:16] == 4'd0);
    assign tens_zero    = (shift_reg[15:12] == 4'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge CLOCK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: next state is defaulted first so no path through the case infers a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = CONV;
            CONV:    if (iter == 3'd7) state_next = LOAD;
            LOAD:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ready is registered so it stays low through reset and rises one edge after release.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            shift_reg  <= '0;
            iter       <= '0;
            ready      <= 1'b0;
            bcd_hun    <= '0;
            bcd_tens   <= '0;
            bcd_units  <= '0;
            seg_hun    <= SEG_BLANK;
            seg_tens   <= SEG_BLANK;
            seg_units  <= SEG_BLANK;
            disp_valid <= 1'b0;
        end else begin
            ready      <= (state_next == IDLE);
            disp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= {12'b0, in_if.in_data};
                        iter      <= '0;
                    end
                end
                CONV: begin
                    shift_reg <= dabble_step(shift_reg);
                    iter      <= iter + 3'd1;
                end
                LOAD: begin
                    bcd_hun    <= shift_reg[19:16];
                    bcd_tens   <= shift_reg[15:12];
                    bcd_units  <= shift_reg[11:8];
                    seg_hun    <= (BLANK_LZ && hun_zero) ? SEG_BLANK : seg_encode(shift_reg[19:16]);
                    seg_tens   <= (BLANK_LZ && hun_zero && tens_zero) ? SEG_BLANK
                                                                      : seg_encode(shift_reg[15:12]);
                    seg_units  <= seg_encode(shift_reg[11:8]);
                    disp_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ave8_bcd_display.sv
// Scoreboard bench for ave8_bcd_display: one instance with leading-zero
// blanking and one without, both fed the same sample stream.
module tb_ave8_bcd_display;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ave8_bcd_display_if if_lz();
    ave8_bcd_display_if if_all();

    assign if_all.in_data  = if_lz.in_data;
    assign if_all.in_valid = if_lz.in_valid;

    logic [0:3] hun_lz, tens_lz, units_lz, hun_all, tens_all, units_all;
    logic [0:6] sh_lz, st_lz, su_lz, sh_all, st_all, su_all;
    logic       dv_lz, dv_all;

    ave8_bcd_display #(.BLANK_LZ(1'b1)) dut_lz (
        .CLOCK(clk), .RESET(rst), .in_if(if_lz.slave),
        .bcd_hun(hun_lz), .bcd_tens(tens_lz), .bcd_units(units_lz),
        .seg_hun(sh_lz), .seg_tens(st_lz), .seg_units(su_lz),
        .disp_valid(dv_lz)
    );

    ave8_bcd_display #(.BLANK_LZ(1'b0)) dut_all (
        .CLOCK(clk), .RESET(rst), .in_if(if_all.slave),
        .bcd_hun(hun_all), .bcd_tens(tens_all), .bcd_units(units_all),
        .seg_hun(sh_all), .seg_tens(st_all), .seg_units(su_all),
        .disp_valid(dv_all)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    localparam logic [0:6] BLANK = 7'b1111111;
    logic [0:6] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
                                 7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100};

    function automatic logic [0:6] exp_seg(input int digit, input bit blank);
        return blank ? BLANK : seg_tab[digit];
    endfunction

    typedef struct {
        int value;
        int acc_cyc;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard push at each accept edge; a reset discards in-flight samples.
    always @(posedge clk) begin
        if (rst)
            sb.delete();
        else if (if_lz.in_valid && if_lz.in_ready)
            sb.push_back('{value: int'(if_lz.in_data), acc_cyc: cyc});
    end

    int disp_count  = 0;
    bit stream_mode = 1'b0;
    int last_dv     = -1;
    bit prev_dv     = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        int   h, t, u;
        if (dv_lz) begin
            disp_count++;
            check("dv_width", prev_dv, 0);
            check("dv_pair", dv_all, 1);
            check("sb_pending", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                h = e.value / 100;
                t = (e.value / 10) % 10;
                u = e.value % 10;
                check("latency", cyc - e.acc_cyc, 10);
                check("bcd_hun", hun_lz, h);
                check("bcd_tens", tens_lz, t);
                check("bcd_units", units_lz, u);
                check("digit_range", (hun_lz <= 2) && (tens_lz <= 9) && (units_lz <= 9), 1);
                check("seg_hun_lz", sh_lz, exp_seg(h, h == 0));
                check("seg_tens_lz", st_lz, exp_seg(t, h == 0 && t == 0));
                check("seg_units_lz", su_lz, exp_seg(u, 1'b0));
                check("bcd_all", {hun_all, tens_all, units_all}, {4'(h), 4'(t), 4'(u)});
                check("seg_hun_all", sh_all, exp_seg(h, 1'b0));
                check("seg_tens_all", st_all, exp_seg(t, 1'b0));
                check("seg_units_all", su_all, exp_seg(u, 1'b0));
            end
            if (stream_mode && last_dv >= 0)
                check("dv_period", cyc - last_dv, 10);
            last_dv = cyc;
        end
        prev_dv = dv_lz;
    end

    task automatic send(input int value);
        for (int k = 0; k < 50 && !if_lz.in_ready; k++) @(negedge clk);
        check("send_ready", if_lz.in_ready, 1);
        if_lz.in_data  = 8'(value);
        if_lz.in_valid = 1'b1;
        @(negedge clk);
        if_lz.in_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 100 && sb.size() != 0; k++) @(negedge clk);
        check("drain_timeout", sb.size(), 0);
        @(negedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, if_lz.in_ready, 0);
        check({tag, "_segs_lz"}, {sh_lz, st_lz, su_lz}, {BLANK, BLANK, BLANK});
        check({tag, "_segs_all"}, {sh_all, st_all, su_all}, {BLANK, BLANK, BLANK});
        check({tag, "_bcd"}, {hun_lz, tens_lz, units_lz, hun_all, tens_all, units_all}, 0);
        check({tag, "_dv"}, {dv_lz, dv_all}, 0);
    endtask

    initial begin
        int base;
        // in_valid high during reset must not cause an accept.
        if_lz.in_data  = 8'd77;
        if_lz.in_valid = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;
        if_lz.in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", if_lz.in_ready, 1);
        check("ready_after_rst_all", if_all.in_ready, 1);

        send(0);
        drain();
        check("zero_one_pulse", disp_count, 1);
        check("zero_segs", {sh_lz, st_lz, su_lz}, {BLANK, BLANK, 7'b0000001});

        send(255);
        drain();
        check("v255_segs", {sh_lz, st_lz, su_lz}, {7'b0010010, 7'b0100100, 7'b0100100});

        send(100);
        drain();
        check("v100_tens", st_lz, 7'b0000001);

        send(9);
        drain();
        repeat (5) @(negedge clk);
        check("hold_segs", {sh_lz, st_lz, su_lz}, {BLANK, BLANK, 7'b0000100});
        check("hold_bcd", units_lz, 4'd9);

        send(7);
        drain();
        check("nolz_segs", {sh_all, st_all, su_all}, {7'b0000001, 7'b0000001, 7'b0001111});

        for (int v = 0; v < 256; v += 37) begin
            send(v);
            drain();
        end

        // Sustained stream: in_data steps every cycle with in_valid held high.
        base        = disp_count;
        last_dv     = -1;
        stream_mode = 1'b1;
        if_lz.in_valid = 1'b1;
        for (int j = 0; j < 50; j++) begin
            if_lz.in_data = 8'(j);
            check("stream_ready", if_lz.in_ready, (j % 10) == 0);
            @(negedge clk);
        end
        if_lz.in_valid = 1'b0;
        drain();
        stream_mode = 1'b0;
        check("stream_count", disp_count - base, 5);

        // Abort: reset lands on E5 of a conversion of 255.
        send(123);
        drain();
        base = disp_count;
        send(255);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        rst = 1'b0;
        repeat (15) @(negedge clk);
        check("abort_no_dv", disp_count, base);
        check("abort_no_publish", {sh_lz, st_lz, su_lz}, {BLANK, BLANK, BLANK});

        send(42);
        drain();
        check("v42_segs", {sh_lz, st_lz, su_lz}, {BLANK, 7'b1001100, 7'b0010010});
        check("final_count", disp_count, base + 1);

        $display("[TB] %0d tests run, %0d failed", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ave8_bcd_display.md
# ave8_bcd_display

Downstream display stage for the 8-sample moving-average block. It accepts the registered 8-bit average through a valid/ready handshake and converts it sequentially to three BCD digits using shift-and-add-3 (double-dabble). It then drives three active-low seven-segment outputs (hundreds, tens, units), with optional leading-zero blanking. It replaces the direct 3-bit-slice decoders at the top level, so the display shows the true decimal value 0–255.

## Interface
- `BLANK_LZ`, default 1: 1 = blank leading zero digits; 0 = always show all three digits.
- `CLOCK` in 1: sole clock, rising edge.
- `RESET` in 1: synchronous, active-high reset.
- `in_data` in [0:7]: binary average; bit 0 is MSB, matching the upstream output ordering.
- `in_valid` in 1: `in_data` is valid. Upstream may tie this high, because its output is held every cycle.
- `in_ready` out 1: block can accept a sample. High only in IDLE.
- `bcd_hun` out [0:3], `bcd_tens` out [0:3], `bcd_units` out [0:3]: registered BCD digits, bit 0 is MSB.
- `seg_hun` out [0:6], `seg_tens` out [0:6], `seg_units` out [0:6]: segments a..g at index 0..6, active-low (0 = lit).
- `disp_valid` out 1: one-cycle pulse when the outputs update.

## Operation
- The FSM has three states.
  - IDLE: `in_ready`=1.
  - CONV: 8 iterations.
  - LOAD: register the outputs.
- IDLE, on `in_valid`&`in_ready` (accept edge):
  - Load a 20-bit shift register with {12'b0, `in_data`}.
  - Set the iteration counter to 0 and go to CONV.
- CONV, each edge:
  - For each of the three BCD nibbles, add 3 if the nibble is ≥5.
  - Shift the whole register left by 1.
  - Increment the counter; after the 8th iteration go to LOAD.
- LOAD, one edge:
  - Copy the nibbles to the `bcd_*` outputs.
  - Encode the `seg_*` outputs, assert `disp_valid` for exactly one cycle, and return to IDLE.
- Segment encoding, digit → a..g:
  - 0 → 0000001, 1 → 1001111, 2 → 0010010, 3 → 0000110, 4 → 1001100
  - 5 → 0100100, 6 → 0100000, 7 → 0001111, 8 → 0000000, 9 → 0000100
  - Blank is 1111111.
- Blanking with `BLANK_LZ`=1:
  - `seg_hun` is blanked if hundreds = 0.
  - `seg_tens` is blanked if hundreds = 0 and tens = 0.
  - `seg_units` is never blanked.
  - `bcd_*` outputs are never blanked.
- Width rules:
  - Input range is 0–255, so hundreds ≤ 2 and the upper bits of `bcd_hun` are always 0.
  - No add-3 correction may produce a nibble > 9 after the final shift. The bench checks this.
- Busy behaviour: while in CONV or LOAD, `in_valid` is ignored (`in_ready`=0) and `in_data` is not sampled. Upstream holds its value, and the next acceptance uses whatever is present in IDLE.
- Outputs hold their last values between updates.
- `RESET`:
  - All `seg_*` = 1111111, all `bcd_*` = 0, `disp_valid` = 0.
  - State goes to IDLE, shift register and counter are cleared.
  - `in_ready` = 0 while `RESET` is high, and 1 from the first cycle after release.

## Timing
- Accept edge E0. CONV occupies E1..E8. LOAD is E9.
- New `seg_*`/`bcd_*` values and `disp_valid`=1 are visible in the cycle after E9. `disp_valid` clears after E10 unless another LOAD occurs.
- `in_ready` rises after E9, so the earliest next accept is E10. Sustained throughput is one conversion per 10 cycles with `in_valid` held high.
- Reset mid-CONV or mid-LOAD aborts the conversion:
  - No `disp_valid` pulse.
  - Outputs take their reset values at the reset edge.
  - No partial result is ever published.
- `RESET` and `in_valid` high on the same edge: reset wins and nothing is accepted.
- All outputs are registered, with no combinational path from `in_*` to outputs.

## Test plan
- Reset, then `in_data`=0, `in_valid` pulsed one cycle, `BLANK_LZ`=1 → after 10 edges: units 0000001, tens/hun 1111111, BCD 0/0/0, one `disp_valid` pulse.
- `in_data`=255 → BCD 2/5/5; `seg_hun` 0010010, `seg_tens` 0100100, `seg_units` 0100100.
- `in_data`=100 → BCD 1/0/0; tens shows 0000001 (not blanked). Then `in_data`=9 → hun/tens blank, units 0000100.
- `BLANK_LZ`=0, `in_data`=7 → `seg_hun`=`seg_tens`=0000001, units 0001111.
- `in_valid` held high with `in_data` stepping 0,1,2,… each cycle → `disp_valid` every 10 cycles; each displayed value equals `in_data` sampled at its accept edge; `in_ready` low for 9 cycles after each accept.
- Load 123 and display it; apply 255 and assert `RESET` at E5 for one cycle → all segs 1111111, BCD 0, no `disp_valid`. The next accept of 42 shows tens 1001100, units 0010010.
